// File: rtl/unidade_busca.sv
// unidade_busca -- fetch/sequencing stage in front of the instruction memory.
//
// Holds the program counter, presents it to the instruction memory and
// decides the next PC from the instruction read back: sequential, jump, jal
// or beq. It waits after reset while the memory self-loads. It stalls on IN
// until the user presses Confirma. It halts on a jump to itself or on a
// branch target outside the memory.
//
// Ports
//   clock          : system clock, all state on the rising edge
//   reset          : synchronous, active-high
//   Instrucao      : instruction word read combinationally at Endereco
//   Igual          : datapath equality for beq, valid in the same cycle
//   Confirma       : asynchronous user button acknowledging IN
//   Endereco       : program counter / instruction memory address
//   Link           : Endereco+1, return address written by jal
//   Executa        : commit strobe gating every datapath write
//   AguardaEntrada : high while stalled on IN
//   Parado         : high once halted
//   Erro           : high when the halt was caused by an illegal target
//   ContInstr      : saturating count of committed instructions
module unidade_busca #(
    parameter int MEM_DEPTH   = 64,
    parameter int INIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      Instrucao,
    input  logic             Igual,
    input  logic             Confirma,
    output logic [31:0]      Endereco,
    output logic [31:0]      Link,
    output logic             Executa,
    output logic             AguardaEntrada,
    output logic             Parado,
    output logic             Erro,
    output logic [CNT_W-1:0] ContInstr
);

    localparam int                INIT_W    = (INIT_CYCLES < 1) ? 1 : $clog2(INIT_CYCLES + 1);
    localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_CYCLES);
    localparam logic [31:0]       DEPTH     = 32'(MEM_DEPTH);
    localparam logic [31:0]       LAST_ADDR = 32'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [4:0] OP_JUMP = 5'b10010;
    localparam logic [4:0] OP_JAL  = 5'b10011;
    localparam logic [4:0] OP_BEQ  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;

    typedef enum logic [1:0] {
        INICIO    = 2'd0,
        BUSCA     = 2'd1,
        ESPERA_IN = 2'd2,
        PARADO    = 2'd3
    } estado_t;

    estado_t           estado_r;
    logic [INIT_W-1:0] init_cnt_r;

    logic conf_sync1_r;
    logic conf_sync2_r;
    logic conf_prev_r;
    logic conf_edge_r;

    logic [4:0]  opcode_s;
    logic [31:0] alvo_s;
    logic        salta_s;
    logic        alvo_ilegal_s;
    logic        auto_salto_s;
    logic [31:0] seq_pc_s;
    logic        executa_s;
    logic        unused_campo_c_s;

    // Field C is consumed by the datapath only.
    assign unused_campo_c_s = ^Instrucao[8:0];

    // Link is the unwrapped return address, even at the last memory word.
    assign Link    = Endereco + 32'd1;
    assign Executa = executa_s;

    // Decode the fetched word, resolve the branch target and the commit strobe.
    always_comb begin
        opcode_s = Instrucao[31:27];
        case (opcode_s)
            OP_JUMP: begin
                alvo_s  = {23'd0, Instrucao[26:18]};
                salta_s = 1'b1;
            end
            OP_JAL: begin
                alvo_s  = {23'd0, Instrucao[17:9]};
                salta_s = 1'b1;
            end
            OP_BEQ: begin
                alvo_s  = {23'd0, Instrucao[26:18]};
                salta_s = Igual;
            end
            default: begin
                alvo_s  = 32'd0;
                salta_s = 1'b0;
            end
        endcase

        alvo_ilegal_s = salta_s && (alvo_s >= DEPTH);
        // Only a plain jump to itself halts; jal/beq to self keep looping.
        auto_salto_s  = (opcode_s == OP_JUMP) && (alvo_s == Endereco);

        if (Endereco == LAST_ADDR) begin
            seq_pc_s = 32'd0;
        end else begin
            seq_pc_s = Endereco + 32'd1;
        end

        // No commit while reset is asserted, whatever state is held.
        if (reset) begin
            executa_s = 1'b0;
        end else begin
            case (estado_r)
                BUSCA:     executa_s = (opcode_s != OP_IN);
                ESPERA_IN: executa_s = conf_edge_r;
                default:   executa_s = 1'b0;
            endcase
        end
    end

    // Two-flop synchronizer for the button followed by a registered rising-edge detector.
    always_ff @(posedge clock) begin
        if (reset) begin
            conf_sync1_r <= 1'b0;
            conf_sync2_r <= 1'b0;
            conf_prev_r  <= 1'b0;
            conf_edge_r  <= 1'b0;
        end else begin
            conf_sync1_r <= Confirma;
            conf_sync2_r <= conf_sync1_r;
            conf_prev_r  <= conf_sync2_r;
            conf_edge_r  <= conf_sync2_r & ~conf_prev_r;
        end
    end

    // Sequencing FSM: PC, status outputs and committed-instruction counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_r       <= INICIO;
            init_cnt_r     <= INIT_LOAD;
            Endereco       <= 32'd0;
            AguardaEntrada <= 1'b0;
            Parado         <= 1'b0;
            Erro           <= 1'b0;
            ContInstr      <= {CNT_W{1'b0}};
        end else begin
            if (executa_s && (ContInstr != CNT_MAX)) begin
                ContInstr <= ContInstr + CNT_W'(1);
            end

            case (estado_r)
                INICIO: begin
                    // Hold PC at 0 until the memory has finished loading.
                    if (init_cnt_r == {INIT_W{1'b0}}) begin
                        estado_r <= BUSCA;
                    end else begin
                        init_cnt_r <= init_cnt_r - INIT_W'(1);
                    end
                end
                BUSCA: begin
                    if (opcode_s == OP_IN) begin
                        estado_r       <= ESPERA_IN;
                        AguardaEntrada <= 1'b1;
                    end else if (alvo_ilegal_s) begin
                        // The instruction still commits (jal link write); PC stays on it.
                        estado_r <= PARADO;
                        Parado   <= 1'b1;
                        Erro     <= 1'b1;
                    end else if (salta_s && auto_salto_s) begin
                        estado_r <= PARADO;
                        Parado   <= 1'b1;
                    end else if (salta_s) begin
                        Endereco <= alvo_s;
                    end else begin
                        Endereco <= seq_pc_s;
                    end
                end
                ESPERA_IN: begin
                    if (conf_edge_r) begin
                        Endereco       <= seq_pc_s;
                        AguardaEntrada <= 1'b0;
                        estado_r       <= BUSCA;
                    end
                end
                PARADO: begin
                    estado_r <= PARADO;
                end
                default: begin
                    estado_r <= INICIO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca -- self-checking bench for unidade_busca.
// An instruction memory array feeds the DUT. A cycle-level reference model
// tracks PC, stall/halt status and the commit count from the instruction set
// rules. It also tracks the history of the Confirma input. Every cycle all
// DUT outputs are compared with the model.
`timescale 1ns/1ps
module tb_unidade_busca;

    localparam int MEM_DEPTH   = 64;
    localparam int INIT_CYCLES = 2;
    localparam int CNT_W       = 16;
    localparam int HIST_N      = 4096;

    localparam logic [4:0] OP_SEQ  = 5'b00001;
    localparam logic [4:0] OP_JUMP = 5'b10010;
    localparam logic [4:0] OP_JAL  = 5'b10011;
    localparam logic [4:0] OP_BEQ  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      Instrucao;
    logic             Igual = 1'b0;
    logic             Confirma = 1'b0;
    logic [31:0]      Endereco;
    logic [31:0]      Link;
    logic             Executa;
    logic             AguardaEntrada;
    logic             Parado;
    logic             Erro;
    logic [CNT_W-1:0] ContInstr;

    logic [31:0] mem [0:MEM_DEPTH-1];

    unidade_busca #(
        .MEM_DEPTH  (MEM_DEPTH),
        .INIT_CYCLES(INIT_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .Instrucao     (Instrucao),
        .Igual         (Igual),
        .Confirma      (Confirma),
        .Endereco      (Endereco),
        .Link          (Link),
        .Executa       (Executa),
        .AguardaEntrada(AguardaEntrada),
        .Parado        (Parado),
        .Erro          (Erro),
        .ContInstr     (ContInstr)
    );

    always #5 clock = ~clock;

    // Combinational instruction memory read
    assign Instrucao = mem[Endereco[5:0]];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int first_exec = -1;
    bit hist [0:HIST_N-1];

    // reference model state
    int m_pc;
    int m_cnt;
    bit m_wait;
    bit m_halt;
    bit m_err;

    // stimulus controls
    int igual_mode  = 0;   // 0: Igual=0, 1: Igual=1, 2: random
    bit conf_random = 1'b0;
    bit conf_level  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit conf_at(input int k);
        if (k < 0 || k >= HIST_N) return 1'b0;
        return hist[k];
    endfunction

    // Compare DUT with the model for the current cycle, then advance the model.
    task automatic eval();
        logic [31:0] ins;
        logic [4:0]  op;
        int          tgt;
        bit          taken;
        bit          running;
        bit          edge_seen;
        bit          e_exec;

        if (cyc < HIST_N) hist[cyc] = Confirma;
        ins   = mem[m_pc];
        op    = ins[31:27];
        taken = 1'b0;
        tgt   = 0;
        if (op == OP_JUMP) begin taken = 1'b1; tgt = int'(ins[26:18]); end
        else if (op == OP_JAL) begin taken = 1'b1; tgt = int'(ins[17:9]); end
        else if (op == OP_BEQ) begin taken = Igual; tgt = int'(ins[26:18]); end

        running   = (cyc > INIT_CYCLES) && !m_halt;
        // press seen as 0->1 in the samples taken 4 and 3 cycles ago
        edge_seen = conf_at(cyc - 3) && !conf_at(cyc - 4);
        if (!running)    e_exec = 1'b0;
        else if (m_wait) e_exec = edge_seen;
        else             e_exec = (op != OP_IN);

        check("Endereco", Endereco, 32'(m_pc));
        check("Link", Link, 32'(m_pc + 1));
        check("Executa", 32'(Executa), 32'(e_exec));
        check("AguardaEntrada", 32'(AguardaEntrada), 32'(m_wait));
        check("Parado", 32'(Parado), 32'(m_halt));
        check("Erro", 32'(Erro), 32'(m_err));
        check("ContInstr", 32'(ContInstr), 32'(m_cnt));
        if (Executa && first_exec < 0) first_exec = cyc;

        if (e_exec && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (running) begin
            if (m_wait) begin
                if (edge_seen) begin
                    m_wait = 1'b0;
                    m_pc   = (m_pc + 1) % MEM_DEPTH;
                end
            end else if (op == OP_IN) begin
                m_wait = 1'b1;
            end else if (taken) begin
                if (tgt >= MEM_DEPTH) begin
                    m_halt = 1'b1;
                    m_err  = 1'b1;
                end else if (op == OP_JUMP && tgt == m_pc) begin
                    m_halt = 1'b1;
                end else begin
                    m_pc = tgt;
                end
            end else begin
                m_pc = (m_pc + 1) % MEM_DEPTH;
            end
        end
    endtask

    task automatic drive_inputs();
        if (igual_mode == 2) Igual = 1'($urandom_range(0, 1));
        else                 Igual = (igual_mode == 1);
        if (conf_random && $urandom_range(0, 5) == 0) conf_level = ~conf_level;
        Confirma = conf_level;
    endtask

    task automatic step();
        @(posedge clock); #1;
        cyc++;
        drive_inputs();
        @(negedge clock);
        eval();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        drive_inputs();
        @(posedge clock); #1;
        reset      = 1'b0;
        cyc        = 0;
        m_pc       = 0;
        m_cnt      = 0;
        m_wait     = 1'b0;
        m_halt     = 1'b0;
        m_err      = 1'b0;
        first_exec = -1;
        for (int i = 0; i < HIST_N; i++) hist[i] = 1'b0;
        drive_inputs();
        @(negedge clock);
        eval();
    endtask

    task automatic fill_seq();
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = {OP_SEQ, 27'(i)};
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          r;
        int          t;
        w = $urandom;
        r = $urandom_range(0, 11);
        t = $urandom_range(0, 70);
        case (r)
            0, 1:    w[31:27] = OP_JUMP;
            2:       w[31:27] = OP_JAL;
            3, 4, 5: w[31:27] = OP_BEQ;
            6:       w[31:27] = OP_IN;
            7:       w[31:27] = 5'(24 + $urandom_range(0, 7));
            default: w[31:27] = 5'($urandom_range(0, 17));
        endcase
        if (w[31:27] == OP_JAL) w[17:9]  = 9'(t);
        else                    w[26:18] = 9'(t);
        return w;
    endfunction

    initial begin
        // Scenario A: beq not taken, IN stall, second press ignored, self-jump halt
        fill_seq();
        mem[2]  = {OP_BEQ, 9'd10, 18'd0};
        mem[5]  = {OP_IN, 27'd0};
        mem[18] = {OP_JUMP, 9'd18, 18'd0};
        igual_mode  = 0;
        conf_random = 1'b0;
        conf_level  = 1'b0;
        do_reset();
        run(11);
        check("first_exec_cycle", 32'(first_exec), 32'd3);
        check("stall_at_in", Endereco, 32'd5);
        conf_level = 1'b1; run(2);
        conf_level = 1'b0; run(6);
        conf_level = 1'b1; run(2);
        conf_level = 1'b0; run(40);
        check("selfjump_parado", 32'(Parado), 32'd1);
        check("selfjump_pc", Endereco, 32'd18);
        check("selfjump_erro", 32'(Erro), 32'd0);

        // Reset from PARADO; button held from before the stall never commits
        conf_level = 1'b1;
        do_reset();
        check("reset_parado_pc", Endereco, 32'd0);
        run(20);
        check("held_button_waits", 32'(AguardaEntrada), 32'd1);
        check("held_button_pc", Endereco, 32'd5);

        // Reset from ESPERA_IN; the start-up delay repeats
        conf_level = 1'b0;
        do_reset();
        run(5);

        // Scenario B: beq taken, jal link, wrap at 63, illegal jump target
        fill_seq();
        mem[2]  = {OP_BEQ, 9'd10, 18'd0};
        mem[10] = {OP_JUMP, 9'd31, 18'd0};
        mem[31] = {OP_JAL, 9'd0, 9'd33, 9'd0};
        mem[33] = {OP_JUMP, 9'd62, 18'd0};
        mem[3]  = {OP_JUMP, 9'd9, 18'd0};
        mem[9]  = {OP_JUMP, 9'd100, 18'd0};
        igual_mode = 1;
        do_reset();
        run(6);
        check("beq_taken_pc", Endereco, 32'd10);
        run(1);
        check("jal_link", Link, 32'd32);
        run(4);
        check("wrap_to_zero", Endereco, 32'd0);
        igual_mode = 0;
        run(15);
        check("illegal_parado", 32'(Parado), 32'd1);
        check("illegal_erro", 32'(Erro), 32'd1);
        check("illegal_pc", Endereco, 32'd9);

        // Scenario C: random programs, random Igual/Confirma, mid-run resets
        igual_mode  = 2;
        conf_random = 1'b1;
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] = rand_instr();
            do_reset();
            run($urandom_range(20, 120));
            do_reset();
            run(200);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
